// File: rtl/masked_sbox_bram_feeder_if.sv
// masked_sbox_bram_feeder_if: upstream, BRAM and downstream signals of the S-box BRAM feeder.
interface masked_sbox_bram_feeder_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_sel;
   logic [7:0] in_share0;
   logic [7:0] in_share1;
   logic [9:0] bram_addra;
   logic [9:0] bram_addrb;
   logic       bram_en;
   logic       bram_rst;
   logic [7:0] bram_doa;
   logic [7:0] bram_dob;
   logic [7:0] fresh_rand;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_share0;
   logic [7:0] out_share1;
   modport master (
      output in_valid, in_sel, in_share0, in_share1, bram_doa, bram_dob, fresh_rand, out_ready,
      input  in_ready, bram_addra, bram_addrb, bram_en, bram_rst, out_valid, out_share0, out_share1
   );
   modport slave (
      input  in_valid, in_sel, in_share0, in_share1, bram_doa, bram_dob, fresh_rand, out_ready,
      output in_ready, bram_addra, bram_addrb, bram_en, bram_rst, out_valid, out_share0, out_share1
   );
endinterface

// File: rtl/masked_sbox_bram_feeder.sv
// masked_sbox_bram_feeder: credit-guarded feeder and output FIFO around a dual-port masked S-box BRAM.
// Define MASK_REFRESH_EN to re-mask both stored shares with fresh_rand at FIFO write.
module masked_sbox_bram_feeder #(
   parameter int FIFO_DEPTH = 4,
   parameter int BRAM_LAT   = 2
) (
   input logic                      clk,
   input logic                      rst,
   masked_sbox_bram_feeder_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [BRAM_LAT-1:0] r_vp;
   logic                r_bram_rst;
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [PW:0]         r_count;
   logic [15:0]         r_mem [FIFO_DEPTH];
   logic                w_fire;
   logic                w_wr;
   logic                w_rd;
   logic [15:0]         w_entry;
   assign bus.bram_addra = {bus.in_sel, bus.in_share0};
   assign bus.bram_addrb = {bus.in_sel, bus.in_share1};
   assign bus.bram_rst   = r_bram_rst;
   // Credits include bytes still inside the BRAM, so every result finds a free slot.
   assign bus.in_ready   = !r_bram_rst && (($countones(r_vp) + int'(r_count)) < FIFO_DEPTH);
   assign w_fire         = bus.in_valid & bus.in_ready;
   assign bus.bram_en    = w_fire | (|r_vp);
   assign w_wr           = bus.bram_en & r_vp[BRAM_LAT-1];
   assign bus.out_valid  = r_count != '0;
   assign w_rd           = bus.out_valid & bus.out_ready;
   assign bus.out_share0 = r_mem[r_rptr][15:8];
   assign bus.out_share1 = r_mem[r_rptr][7:0];
`ifdef MASK_REFRESH_EN
   assign w_entry = {bus.bram_doa ^ bus.fresh_rand, bus.bram_dob ^ bus.fresh_rand};
`else
   logic w_unused_rand;
   assign w_unused_rand = ^bus.fresh_rand;
   assign w_entry       = {bus.bram_doa, bus.bram_dob};
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vp       <= '0;
         r_bram_rst <= 1'b1;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_bram_rst <= 1'b0;
         if (bus.bram_en) r_vp <= {r_vp[BRAM_LAT-2:0], w_fire};
         if (w_wr) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (PW+1)'(w_wr) - (PW+1)'(w_rd);
      end
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_wr && !w_rd && r_count == (PW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_masked_sbox_bram_feeder.sv
// tb_masked_sbox_bram_feeder: table vectors, hand sequences and random traffic against a queue scoreboard.
module tb_masked_sbox_bram_feeder;
   localparam int DEPTH = 4;
`ifdef MASK_REFRESH_EN
   localparam logic [7:0] REF_MASK = 8'h5A;
`else
   localparam logic [7:0] REF_MASK = 8'h00;
`endif
   typedef struct {
      logic [1:0] sel;
      logic [7:0] s0, s1;
      logic [9:0] aa, ab;
      logic [7:0] o0, o1;
   } vec_t;
   typedef struct {
      int         t;
      logic [7:0] o0, o1;
   } item_t;
   logic clk = 0;
   logic rst = 1;
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, since_rel = 0, n_pop = 0;
   item_t q[$];
   vec_t  tv[5];
   logic [7:0] lat_a, lat_b;
   logic exp_rdy, exp_vld, exp_en;
   masked_sbox_bram_feeder_if bus();
   masked_sbox_bram_feeder #(.FIFO_DEPTH(DEPTH), .BRAM_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask
   // BRAM model: synchronous array read plus output register, both gated by enable.
   always @(posedge clk) begin
      if (bus.bram_en) begin
         lat_a <= bus.bram_addra[7:0] ^ {6'b0, bus.bram_addra[9:8]};
         lat_b <= bus.bram_addrb[7:0] + 8'd1;
      end
      if (bus.bram_rst) begin
         bus.bram_doa <= 8'h00;
         bus.bram_dob <= 8'h00;
      end else if (bus.bram_en) begin
         bus.bram_doa <= lat_a;
         bus.bram_dob <= lat_b;
      end
   end
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      since_rel <= rst ? 0 : since_rel + 1;
   end
   // Scoreboard: a byte accepted at edge t is visible from edge t+2 until popped.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_share0", bus.out_share0, 0);
         chk("rst_out_share1", bus.out_share1, 0);
         chk("rst_bram_en", bus.bram_en, 0);
         chk("rst_bram_rst", bus.bram_rst, 1);
         q.delete();
      end else begin
         exp_rdy = since_rel >= 1 && q.size() < DEPTH;
         exp_vld = 0;
         if (q.size() > 0) exp_vld = q[0].t <= cyc - 2;
         exp_en = bus.in_valid && exp_rdy;
         foreach (q[i]) if (q[i].t >= cyc - 1) exp_en = 1;
         chk("bram_rst", bus.bram_rst, since_rel == 0);
         chk("in_ready", bus.in_ready, exp_rdy);
         chk("out_valid", bus.out_valid, exp_vld);
         chk("bram_en", bus.bram_en, exp_en);
         chk("bram_addra", bus.bram_addra, {bus.in_sel, bus.in_share0});
         chk("bram_addrb", bus.bram_addrb, {bus.in_sel, bus.in_share1});
         if (exp_vld) begin
            chk("head_share0", bus.out_share0, q[0].o0);
            chk("head_share1", bus.out_share1, q[0].o1);
            if (bus.out_ready) begin
               void'(q.pop_front());
               n_pop++;
            end
         end
         if (bus.in_valid && exp_rdy)
            q.push_back('{cyc + 1,
                          (bus.in_share0 ^ {6'b0, bus.in_sel}) ^ REF_MASK,
                          (bus.in_share1 + 8'd1) ^ REF_MASK});
      end
   end
   task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] s0, input logic [7:0] s1);
      bus.in_valid  = v;
      bus.in_sel    = sel;
      bus.in_share0 = s0;
      bus.in_share1 = s1;
   endtask
   task automatic send(input logic [1:0] sel, input logic [7:0] s0, input logic [7:0] s1, output bit ok);
      drive(1, sel, s0, s1);
      ok = 0;
      for (int w = 0; w < 20 && !ok; w++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask
   task automatic send_check(input vec_t v);
      bit ok;
      drive(1, v.sel, v.s0, v.s1);
      #1;
      chk("vec_addra", bus.bram_addra, v.aa);
      chk("vec_addrb", bus.bram_addrb, v.ab);
      send(v.sel, v.s0, v.s1, ok);
      if (ok) begin
         @(negedge clk);
         chk("lat_cycle1_valid", bus.out_valid, 0);
         @(negedge clk);
         chk("lat_cycle2_valid", bus.out_valid, 0);
         @(negedge clk);
         chk("lat_cycle3_valid", bus.out_valid, 1);
         chk("vec_share0", bus.out_share0, v.o0 ^ REF_MASK);
         chk("vec_share1", bus.out_share1, v.o1 ^ REF_MASK);
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      int acc, p0;
      tv[0] = '{2'b01, 8'h3C, 8'hA5, 10'h13C, 10'h1A5, 8'h3D, 8'hA6};
      tv[1] = '{2'b10, 8'h00, 8'hFF, 10'h200, 10'h2FF, 8'h02, 8'h00};
      tv[2] = '{2'b11, 8'hF0, 8'h7F, 10'h3F0, 10'h37F, 8'hF3, 8'h80};
      tv[3] = '{2'b00, 8'h00, 8'h00, 10'h000, 10'h000, 8'h00, 8'h01};
      tv[4] = '{2'b11, 8'h03, 8'h80, 10'h303, 10'h380, 8'h00, 8'h81};
      drive(0, 0, 0, 0);
      bus.out_ready  = 0;
      bus.fresh_rand = (REF_MASK != 0) ? REF_MASK : 8'($urandom);
      repeat (3) @(posedge clk);
      #1 rst = 0;
      bus.out_ready = 1;
      for (int k = 0; k < 5; k++) send_check(tv[k]);
      // Back-to-back stream with a ready sink.
      acc = 0;
      p0  = n_pop;
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 8'(i), 8'(i));
         @(negedge clk);
         if (bus.in_ready) acc++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 0;
      chk("b2b_accepts", acc, 16);
      repeat (3) @(posedge clk);
      #1 chk("b2b_pops", n_pop - p0, 16);
      // Stalled sink: only FIFO_DEPTH bytes may enter.
      bus.out_ready = 0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 2'($urandom), 8'($urandom), 8'($urandom));
         @(negedge clk);
         if (bus.in_ready) acc++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 0;
      chk("bp_accepts", acc, DEPTH);
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      p0 = n_pop;
      bus.out_ready = 1;
      repeat (8) @(posedge clk);
      #1 chk("bp_drained", n_pop - p0, DEPTH);
      chk("bp_empty", bus.out_valid, 0);
      // Reset with two bytes buffered and two inside the BRAM.
      bus.out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 8'(8'h40 + i), 8'(8'h50 + i));
         @(posedge clk);
         #1;
      end
      bus.in_valid = 0;
      chk("rstmid_buffered_valid", bus.out_valid, 1);
      rst = 1;
      #1;
      chk("rstmid_out_valid", bus.out_valid, 0);
      chk("rstmid_bram_rst", bus.bram_rst, 1);
      chk("rstmid_in_ready", bus.in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      bus.out_ready = 1;
      p0 = n_pop;
      send_check('{2'b10, 8'h11, 8'h22, 10'h211, 10'h222, 8'h13, 8'h23});
      repeat (6) @(posedge clk);
      #1 chk("rstmid_single_pop", n_pop - p0, 1);
      // Random traffic checked by the scoreboard.
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
         bus.out_ready = $urandom_range(0, 3) != 0;
         if (REF_MASK == 0) bus.fresh_rand = 8'($urandom);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 0;
      bus.out_ready = 1;
      repeat (10) @(posedge clk);
      #1 chk("rand_drain_valid", bus.out_valid, 0);
      chk("rand_drain_queue", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
